// File: rtl/drv_bus_ctrl.sv
// Drive bus controller: decodes the 1581-style CPU address map and sequences ROM/peripheral accesses.
// Optional last-byte ROM buffer is built when DRV_ROM_LASTBYTE_EN is defined.
module drv_bus_ctrl #(
  parameter int         PER_TIMEOUT = 15,
  parameter logic [7:0] OPEN_BUS    = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic [14:0] rom_addr_o,
  output logic        rom_oen_o,
  input  logic [7:0]  rom_data_i,
  output logic [2:0]  per_sel_o,
  output logic [12:0] per_addr_o,
  output logic        per_we_o,
  output logic [7:0]  per_wdata_o,
  input  logic [7:0]  per_rdata_i,
  input  logic        per_ack_i,
  output logic        bus_err_o,
  output logic [2:0]  state_o
);

  // CPU handshake: cpu_req is held with stable address/data until the one-cycle
  // cpu_ack pulse; a request is only sampled in IDLE.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ROM_RD   = 3'd1;
  localparam logic [2:0] S_ROM_CAP  = 3'd2;
  localparam logic [2:0] S_PER_WAIT = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  localparam logic [7:0] TIMEOUT_LAST = 8'(PER_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic        rom_oen_q, rom_oen_d;
  logic [2:0]  per_sel_q, per_sel_d;
  logic [12:0] per_addr_q, per_addr_d;
  logic        per_we_q, per_we_d;
  logic [7:0]  per_wdata_q, per_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic       is_rom;
  logic [2:0] dec_sel;

  assign is_rom  = cpu_addr_i[15];
  assign dec_sel = {cpu_addr_i[15:13] == 3'b011,
                    cpu_addr_i[15:12] == 4'b0100,
                    cpu_addr_i[15:13] == 3'b000};

`ifdef DRV_ROM_LASTBYTE_EN
  logic        lb_valid_q;
  logic [14:0] lb_tag_q;
  logic [7:0]  lb_data_q;
  logic        lb_hit;

  assign lb_hit = lb_valid_q && (lb_tag_q == cpu_addr_i[14:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
    end else if (state_q == S_ROM_CAP) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= rom_addr_q;
      lb_data_q  <= rom_data_i;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    rom_addr_d  = rom_addr_q;
    rom_oen_d   = rom_oen_q;
    per_sel_d   = per_sel_q;
    per_addr_d  = per_addr_q;
    per_we_d    = per_we_q;
    per_wdata_d = per_wdata_q;
    bus_err_d   = bus_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          if (is_rom) begin
            if (cpu_we_i) begin
              bus_err_d = 1'b1;
              cpu_ack_d = 1'b1;
              state_d   = S_RESP;
`ifdef DRV_ROM_LASTBYTE_EN
            end else if (lb_hit) begin
              cpu_rdata_d = lb_data_q;
              cpu_ack_d   = 1'b1;
              state_d     = S_RESP;
`endif
            end else begin
              rom_addr_d = cpu_addr_i[14:0];
              rom_oen_d  = 1'b0;
              state_d    = S_ROM_RD;
            end
          end else if (|dec_sel) begin
            per_sel_d   = dec_sel;
            per_addr_d  = cpu_addr_i[12:0];
            per_we_d    = cpu_we_i;
            per_wdata_d = cpu_wdata_i;
            cnt_d       = '0;
            state_d     = S_PER_WAIT;
          end else begin
            // Unmapped hole: complete immediately with open-bus data.
            if (!cpu_we_i) cpu_rdata_d = OPEN_BUS;
            bus_err_d = 1'b1;
            cpu_ack_d = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_ROM_RD: state_d = S_ROM_CAP;
      S_ROM_CAP: begin
        cpu_rdata_d = rom_data_i;
        rom_oen_d   = 1'b1;
        cpu_ack_d   = 1'b1;
        state_d     = S_RESP;
      end
      S_PER_WAIT: begin
        // A per_ack on the final timeout cycle still counts as a normal completion.
        if (per_ack_i) begin
          if (!per_we_q) cpu_rdata_d = per_rdata_i;
          per_sel_d = '0;
          per_we_d  = 1'b0;
          cpu_ack_d = 1'b1;
          state_d   = S_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (!per_we_q) cpu_rdata_d = OPEN_BUS;
          per_sel_d = '0;
          per_we_d  = 1'b0;
          bus_err_d = 1'b1;
          cpu_ack_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      rom_addr_q  <= '0;
      rom_oen_q   <= 1'b1;
      per_sel_q   <= '0;
      per_addr_q  <= '0;
      per_we_q    <= 1'b0;
      per_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      rom_addr_q  <= rom_addr_d;
      rom_oen_q   <= rom_oen_d;
      per_sel_q   <= per_sel_d;
      per_addr_q  <= per_addr_d;
      per_we_q    <= per_we_d;
      per_wdata_q <= per_wdata_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign rom_addr_o  = rom_addr_q;
  assign rom_oen_o   = rom_oen_q;
  assign per_sel_o   = per_sel_q;
  assign per_addr_o  = per_addr_q;
  assign per_we_o    = per_we_q;
  assign per_wdata_o = per_wdata_q;
  assign bus_err_o   = bus_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_drv_bus_ctrl.sv
// Bench for drv_bus_ctrl: directed accesses, ROM and peripheral models, ack-driven scoreboard.
module tb_drv_bus_ctrl;

  localparam int W = 41;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [14:0] rom_addr;
  logic        rom_oen;
  wire  [7:0]  rom_data;
  logic [2:0]  per_sel;
  logic [12:0] per_addr;
  logic        per_we;
  logic [7:0]  per_wdata;
  logic [7:0]  per_rdata;
  logic        per_ack;
  logic        bus_err;
  logic [2:0]  state;

  int pass_n  = 0;
  int total_n = 0;
  int cyc     = 0;
  int ack_delay = 0;
  int wcnt      = 0;
  logic [7:0] rom_q = 8'h00;

  // {expected ack cycle, expected bus_err, expected cpu_rdata}
  logic [W-1:0] exp_q[$];

  drv_bus_ctrl #(.PER_TIMEOUT(15), .OPEN_BUS(8'hFF)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
    .rom_addr_o(rom_addr), .rom_oen_o(rom_oen), .rom_data_i(rom_data),
    .per_sel_o(per_sel), .per_addr_o(per_addr), .per_we_o(per_we),
    .per_wdata_o(per_wdata), .per_rdata_i(per_rdata), .per_ack_i(per_ack),
    .bus_err_o(bus_err), .state_o(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Mask-ROM model: registered read, high-Z while disabled.
  function automatic logic [7:0] rom_byte(input logic [14:0] a);
    case (a)
      15'h0000: rom_byte = 8'h4C;
      15'h7FFC: rom_byte = 8'hA5;
      15'h7FFD: rom_byte = 8'h1F;
      default:  rom_byte = 8'hEA;
    endcase
  endfunction

  always @(posedge clk) if (!rom_oen) rom_q <= rom_byte(rom_addr);
  assign rom_data = rom_oen ? 8'hzz : rom_q;

  // Peripheral responder: acks in the ack_delay-th selected cycle, never when 0.
  always @(negedge clk) begin
    if (per_sel != 3'b000) begin
      wcnt = wcnt + 1;
      per_ack = (ack_delay != 0) && (wcnt == ack_delay);
    end else begin
      wcnt = 0;
      per_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && cpu_ack) begin
      if (exp_q.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("ack_cycle", cyc, e[40:9]);
        check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e[7:0]});
        check("bus_err", {31'h0, bus_err}, {31'h0, e[8]});
      end
    end
  end

  // driver
  task automatic do_access(input logic [15:0] a, input logic w, input logic [7:0] wd,
                           input logic [7:0] ed, input logic ee, input int lat,
                           input int eoen, input int esel_cyc, input logic [2:0] esel,
                           input int dly, input logic [7:0] prd);
    int oen_n;
    int sel_n;
    bit got;
    @(negedge clk);
    ack_delay = dly;
    per_rdata = prd;
    cpu_addr  = a;
    cpu_we    = w;
    cpu_wdata = wd;
    exp_q.push_back({32'(cyc + lat), ee, ed});
    cpu_req = 1'b1;
    oen_n = 0;
    sel_n = 0;
    got   = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (!rom_oen) oen_n++;
      if (per_sel != 3'b000) sel_n++;
      if (n == 1) begin
        if (eoen != 0) check("rom_addr", {17'h0, rom_addr}, {17'h0, a[14:0]});
        if (esel != 3'b000) begin
          check("per_sel", {29'h0, per_sel}, {29'h0, esel});
          check("per_addr", {19'h0, per_addr}, {19'h0, a[12:0]});
          check("per_we", {31'h0, per_we}, {31'h0, w});
          check("per_wdata", {24'h0, per_wdata}, {24'h0, wd});
        end
      end
      if (cpu_ack) begin
        got = 1'b1;
        cpu_req = 1'b0;
      end
    end
    if (!got) begin
      total_n++;
      $display("FAIL ack_wait: got no ack within 40 cycles for addr %0h expected ack", a);
      cpu_req = 1'b0;
    end
    check("rom_oen_cycles", oen_n, eoen);
    check("per_sel_cycles", sel_n, esel_cyc);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
    per_rdata = '0; per_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ack", {31'h0, cpu_ack}, 32'h0);
    check("rst_cpu_rdata", {24'h0, cpu_rdata}, 32'h0);
    check("rst_rom_oen", {31'h0, rom_oen}, 32'h1);
    check("rst_rom_addr", {17'h0, rom_addr}, 32'h0);
    check("rst_per_bus", {per_sel, per_addr, per_we, per_wdata}, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst_state", {29'h0, state}, 32'h0);
    rst = 1'b0;

    // addr, we, wdata, exp_data, exp_err, latency, oen_cycles, sel_cycles, sel, ack_delay, per_rdata
    do_access(16'h8000, 0, 8'h00, 8'h4C, 0, 3, 2, 0, 3'b000, 0, 8'h00);
`ifdef DRV_ROM_LASTBYTE_EN
    do_access(16'h8000, 0, 8'h00, 8'h4C, 0, 1, 0, 0, 3'b000, 0, 8'h00);
`endif
    do_access(16'hFFFC, 0, 8'h00, 8'hA5, 0, 3, 2, 0, 3'b000, 0, 8'h00);
    do_access(16'hFFFD, 0, 8'h00, 8'h1F, 0, 3, 2, 0, 3'b000, 0, 8'h00);
    do_access(16'h1234, 1, 8'h5A, 8'h1F, 0, 3, 0, 2, 3'b001, 2, 8'h99);
    do_access(16'h1FFF, 0, 8'h00, 8'h11, 0, 2, 0, 1, 3'b001, 1, 8'h11);
    do_access(16'h6010, 0, 8'h00, 8'h3C, 0, 4, 0, 3, 3'b100, 3, 8'h3C);
    do_access(16'h4005, 0, 8'h00, 8'h77, 0, 16, 0, 15, 3'b010, 15, 8'h77);
    do_access(16'h2000, 0, 8'h00, 8'hFF, 1, 1, 0, 0, 3'b000, 0, 8'h00);
    do_access(16'h7FFF, 0, 8'h00, 8'h42, 1, 2, 0, 1, 3'b100, 1, 8'h42);
    do_access(16'h9000, 1, 8'h33, 8'h42, 1, 1, 0, 0, 3'b000, 0, 8'h00);
    do_access(16'h4005, 0, 8'h00, 8'hFF, 1, 16, 0, 15, 3'b010, 0, 8'h55);
    do_access(16'h5000, 0, 8'h00, 8'hFF, 1, 1, 0, 0, 3'b000, 0, 8'h00);

    // abort a ROM read with reset while in ROM_RD
    @(negedge clk);
    cpu_addr = 16'h8000; cpu_we = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    check("abort_in_rom_rd", {29'h0, state}, 32'h1);
    check("abort_oen_low", {31'h0, rom_oen}, 32'h0);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("abort_oen_high", {31'h0, rom_oen}, 32'h1);
    check("abort_idle", {29'h0, state}, 32'h0);
    check("abort_no_ack", {31'h0, cpu_ack}, 32'h0);
    check("abort_err_clr", {31'h0, bus_err}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_access(16'hFFFC, 0, 8'h00, 8'hA5, 0, 3, 2, 0, 3'b000, 0, 8'h00);
`ifdef DRV_ROM_LASTBYTE_EN
    do_access(16'hFFFC, 0, 8'h00, 8'hA5, 0, 1, 0, 0, 3'b000, 0, 8'h00);
`else
    do_access(16'hFFFC, 0, 8'h00, 8'hA5, 0, 3, 2, 0, 3'b000, 0, 8'h00);
`endif

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
